// File: rtl/kbd_event_ctrl_if.sv
// Keyboard event controller bus: ps2_keyboard byte handshake plus CPU event-FIFO port.
// The controller uses the slave modport; the keyboard/CPU side uses master.
interface kbd_event_ctrl_if #(
  parameter int DEPTH = 8
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [7:0]    keydata;
  logic          ready;
  logic          overflow;
  logic          nextdata_n;
  logic          en;
  logic          ev_rd;
  logic          ev_valid;
  logic [9:0]    ev_data;
  logic [CW-1:0] ev_count;
  logic          ovf_clr;
  logic          ev_ovf;

  modport master (
    output keydata, ready, overflow, en, ev_rd, ovf_clr,
    input  nextdata_n, ev_valid, ev_data, ev_count, ev_ovf
  );

  modport slave (
    input  keydata, ready, overflow, en, ev_rd, ovf_clr,
    output nextdata_n, ev_valid, ev_data, ev_count, ev_ovf
  );
endinterface

// File: rtl/kbd_event_ctrl.sv
// Folds E0/F0/E1 scan-code prefixes into {ext,brk,code} events and queues them for software.
// Optional KBD_REPEAT_FILTER_EN drops typematic repeats of the currently held key.
module kbd_event_ctrl #(
  parameter int DEPTH   = 8,
  parameter int E1_SKIP = 7
) (
  input  logic            clk,
  input  logic            clrn,
  kbd_event_ctrl_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int SW = $clog2(E1_SKIP + 1);

  typedef enum logic [1:0] {IDLE, POP, DEC} state_t;

  state_t                  state_q, state_d;
  logic                    nd_q, nd_d, latch;
  logic [7:0]              byte_q;
  logic                    ext_q, ext_d, brk_q, brk_d;
  logic [SW-1:0]           skip_q, skip_d;
  logic                    dec_push, push;
  logic [9:0]              dec_data;
  logic [DEPTH-1:0][9:0]   mem;
  logic [AW-1:0]           wr_ptr, rd_ptr;
  logic [CW-1:0]           count_q;
  logic                    ovf_q, full, empty, do_rd, do_wr, drop;

  // Byte handshake: latch in IDLE, strobe nextdata_n for the single POP cycle, decode in DEC.
  always_comb begin
    state_d = state_q;
    nd_d    = 1'b1;
    latch   = 1'b0;
    case (state_q)
      IDLE: if (bus.ready) begin state_d = POP; nd_d = 1'b0; latch = 1'b1; end
      POP:  state_d = DEC;
      default: state_d = IDLE;
    endcase
    if (bus.overflow) begin
      state_d = IDLE;
      nd_d    = 1'b1;
      latch   = 1'b0;
    end
  end

  always_comb begin
    dec_push = 1'b0;
    dec_data = '0;
    ext_d    = ext_q;
    brk_d    = brk_q;
    skip_d   = skip_q;
    if (state_q == DEC && bus.en) begin
      if (skip_q != '0) begin
        // Pause has no break code; its tail is swallowed and reported once.
        skip_d = skip_q - SW'(1);
        if (skip_q == SW'(1)) begin dec_push = 1'b1; dec_data = {2'b10, 8'hE1}; end
      end else begin
        case (byte_q)
          8'hE1: begin skip_d = SW'(E1_SKIP); ext_d = 1'b0; brk_d = 1'b0; end
          8'hE0: ext_d = 1'b1;
          8'hF0: brk_d = 1'b1;
          8'h00, 8'hAA, 8'hFA, 8'hFE, 8'hFF: begin ext_d = 1'b0; brk_d = 1'b0; end
          default: begin
            dec_push = 1'b1;
            dec_data = {ext_q, brk_q, byte_q};
            ext_d    = 1'b0;
            brk_d    = 1'b0;
          end
        endcase
      end
    end
    if (bus.overflow || !bus.en) begin
      ext_d  = 1'b0;
      brk_d  = 1'b0;
      skip_d = '0;
    end
    if (bus.overflow) dec_push = 1'b0;
  end

`ifdef KBD_REPEAT_FILTER_EN
  logic       held_v_q, held_v_d;
  logic [8:0] held_q, held_d;
  logic       held_hit;

  assign held_hit = held_v_q && (held_q == {dec_data[9], dec_data[7:0]});

  always_comb begin
    push     = dec_push;
    held_v_d = held_v_q;
    held_d   = held_q;
    if (dec_push) begin
      if (!dec_data[8]) begin
        if (held_hit) push = 1'b0;
        else begin held_v_d = 1'b1; held_d = {dec_data[9], dec_data[7:0]}; end
      end else if (held_hit) begin
        held_v_d = 1'b0;
      end
    end
    if (!bus.en) held_v_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!clrn) begin
      held_v_q <= 1'b0;
      held_q   <= '0;
    end else begin
      held_v_q <= held_v_d;
      held_q   <= held_d;
    end
  end
`else
  assign push = dec_push;
`endif

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign do_rd = bus.ev_rd && !empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign do_wr = push && (!full || do_rd);
  assign drop  = push && full && !do_rd;

  always_ff @(posedge clk) begin
    if (!clrn) begin
      state_q <= IDLE;
      nd_q    <= 1'b1;
      byte_q  <= '0;
      ext_q   <= 1'b0;
      brk_q   <= 1'b0;
      skip_q  <= '0;
      mem     <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      nd_q    <= nd_d;
      if (latch) byte_q <= bus.keydata;
      ext_q   <= ext_d;
      brk_q   <= brk_d;
      skip_q  <= skip_d;
      if (do_wr) begin
        mem[wr_ptr] <= dec_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_rd) rd_ptr <= rd_ptr + AW'(1);
      case ({do_wr, do_rd})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
      if (bus.overflow || drop) ovf_q <= 1'b1;
      else if (bus.ovf_clr)     ovf_q <= 1'b0;
    end
  end

  assign bus.nextdata_n = nd_q;
  assign bus.ev_valid   = !empty;
  assign bus.ev_data    = mem[rd_ptr];
  assign bus.ev_count   = count_q;
  assign bus.ev_ovf     = ovf_q;
endmodule

// File: tb/tb_kbd_event_ctrl.sv
// Random and directed stimulus for kbd_event_ctrl against an event-level reference model.
module tb_kbd_event_ctrl;
  localparam int DEPTH   = 8;
  localparam int E1_SKIP = 7;

  logic clk = 1'b0;
  logic clrn;
  always #5 clk = ~clk;

  kbd_event_ctrl_if #(.DEPTH(DEPTH)) bus ();
  kbd_event_ctrl #(.DEPTH(DEPTH), .E1_SKIP(E1_SKIP)) dut (.clk(clk), .clrn(clrn), .bus(bus));

  int checks   = 0;
  int failures = 0;

  // Keyboard-side byte source and drive values for the next edge.
  logic [7:0] src_q[$];
  bit d_rst_n = 1'b0, d_ovf = 1'b0, d_en = 1'b1, d_rd = 1'b0, d_clr = 1'b0;

  // Reference model: occupancy countdown, prefix flags, event queue.
  int         busy  = 0;
  logic [7:0] mbyte = 8'h00;
  bit         mext, mbrk, movf, mhv;
  int         mskip = 0;
  logic [8:0] mheld = '0;
  logic [9:0] evq[$];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      if (failures <= 40) $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic model_step(input bit rst_n, input bit rdy, input logic [7:0] kd,
                            input bit ovfl, input bit en_i, input bit rd, input bit clr);
    bit pushed, full, rdok, dropped;
    logic [9:0] pv, tmp;
    if (!rst_n) begin
      busy = 0; mext = 0; mbrk = 0; mskip = 0; mhv = 0; movf = 0;
      evq.delete();
      return;
    end
    pushed = 0; pv = '0; dropped = 0;
    if (busy == 1 && en_i && !ovfl) begin
      if (mskip > 0) begin
        mskip--;
        if (mskip == 0) begin pushed = 1; pv = 10'h2E1; end
      end else if (mbyte == 8'hE1) begin mskip = E1_SKIP; mext = 0; mbrk = 0; end
      else if (mbyte == 8'hE0) mext = 1;
      else if (mbyte == 8'hF0) mbrk = 1;
      else if (mbyte inside {8'h00, 8'hAA, 8'hFA, 8'hFE, 8'hFF}) begin mext = 0; mbrk = 0; end
      else begin pushed = 1; pv = {mext, mbrk, mbyte}; mext = 0; mbrk = 0; end
    end
`ifdef KBD_REPEAT_FILTER_EN
    if (pushed) begin
      if (!pv[8]) begin
        if (mhv && mheld == {pv[9], pv[7:0]}) pushed = 0;
        else begin mhv = 1; mheld = {pv[9], pv[7:0]}; end
      end else if (mhv && mheld == {pv[9], pv[7:0]}) mhv = 0;
    end
    if (!en_i) mhv = 0;
`endif
    full = (evq.size() == DEPTH);
    rdok = rd && (evq.size() > 0);
    if (rdok) tmp = evq.pop_front();
    if (pushed) begin
      if (full && !rdok) dropped = 1;
      else evq.push_back(pv);
    end
    if (ovfl || dropped) movf = 1;
    else if (clr) movf = 0;
    if (ovfl || !en_i) begin mext = 0; mbrk = 0; mskip = 0; end
    if (ovfl) busy = 0;
    else if (busy > 0) busy--;
    else if (rdy) begin busy = 2; mbyte = kd; end
  endtask

  task automatic cmp_all();
    chk("nextdata_n", 32'(bus.nextdata_n), (busy == 2) ? 0 : 1);
    chk("ev_valid", 32'(bus.ev_valid), 32'(evq.size() > 0));
    chk("ev_count", 32'(bus.ev_count), evq.size());
    chk("ev_ovf", 32'(bus.ev_ovf), 32'(movf));
    if (evq.size() > 0) chk("ev_data", 32'(bus.ev_data), 32'(evq[0]));
  endtask

  task automatic tick();
    bit pop_now;
    logic [7:0] tmp;
    bus.ready    = (src_q.size() > 0);
    bus.keydata  = bus.ready ? src_q[0] : 8'h00;
    bus.overflow = d_ovf;
    bus.en       = d_en;
    bus.ev_rd    = d_rd;
    bus.ovf_clr  = d_clr;
    clrn         = d_rst_n;
    pop_now = (busy == 2);
    model_step(d_rst_n, bus.ready, bus.keydata, d_ovf, d_en, d_rd, d_clr);
    if (pop_now && src_q.size() > 0) tmp = src_q.pop_front();
    @(posedge clk);
    @(negedge clk);
    cmp_all();
  endtask

  task automatic send(input logic [7:0] b);
    src_q.push_back(b);
  endtask

  task automatic settle();
    int n = 0;
    while ((src_q.size() > 0 || busy != 0) && n < 400) begin tick(); n++; end
    chk("settle_timeout", 32'(n >= 400), 0);
  endtask

  task automatic pop_expect(input string name, input logic [9:0] exp);
    chk({name, "_valid"}, 32'(bus.ev_valid), 1);
    chk(name, 32'(bus.ev_data), 32'(exp));
    d_rd = 1; tick(); d_rd = 0;
  endtask

  initial begin
    int n, nlow;
    logic [7:0] tbl [16];
    tbl = '{8'h1C, 8'h1C, 8'hF0, 8'hE0, 8'h75, 8'hE1, 8'h00, 8'hAA,
            8'h12, 8'h33, 8'hFA, 8'hF0, 8'h1C, 8'h5A, 8'hE0, 8'hFF};
    @(negedge clk);
    d_rst_n = 0;
    repeat (3) tick();
    d_rst_n = 1;
    chk("rst_nextdata_n", 32'(bus.nextdata_n), 1);
    chk("rst_ev_valid", 32'(bus.ev_valid), 0);
    chk("rst_ev_data", 32'(bus.ev_data), 0);
    chk("rst_ev_count", 32'(bus.ev_count), 0);
    chk("rst_ev_ovf", 32'(bus.ev_ovf), 0);

    // First byte into an idle, empty controller.
    send(8'h1C);
    n = 0; nlow = 0;
    do begin
      tick(); n++;
      if (bus.nextdata_n == 1'b0) nlow++;
    end while (!bus.ev_valid && n < 10);
    chk("latency", n, 3);
    chk("pop_low_cycles", nlow, 1);
    send(8'hF0); send(8'h1C);
    settle();
    chk("count_make_break", 32'(bus.ev_count), 2);
    pop_expect("make_1c", 10'h01C);
    pop_expect("break_1c", 10'h11C);

    send(8'hE0); send(8'h75); send(8'hE0); send(8'hF0); send(8'h75);
    settle();
    pop_expect("ext_make", 10'h275);
    pop_expect("ext_break", 10'h375);

    foreach (tbl[i]) if (i < 0) send(tbl[i]);
    send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
    send(8'hF0); send(8'h14); send(8'hF0); send(8'h77);
    settle();
    chk("pause_count", 32'(bus.ev_count), 1);
    pop_expect("pause", 10'h2E1);

    for (int i = 0; i <= DEPTH; i++) send(8'h10 + 8'(i));
    settle();
    chk("full_count", 32'(bus.ev_count), DEPTH);
    chk("full_ovf", 32'(bus.ev_ovf), 1);
    chk("full_head", 32'(bus.ev_data), 32'h010);
    d_clr = 1; tick(); d_clr = 0;
    chk("ovf_cleared", 32'(bus.ev_ovf), 0);
    for (int i = 0; i < DEPTH; i++) pop_expect("drain", 10'h010 + 10'(i));

    send(8'h1C); send(8'h1C); send(8'h1C); send(8'hF0); send(8'h1C);
    settle();
`ifdef KBD_REPEAT_FILTER_EN
    chk("repeat_count", 32'(bus.ev_count), 2);
    pop_expect("repeat_make", 10'h01C);
`else
    chk("repeat_count", 32'(bus.ev_count), 4);
    pop_expect("repeat_make0", 10'h01C);
    pop_expect("repeat_make1", 10'h01C);
    pop_expect("repeat_make2", 10'h01C);
`endif
    pop_expect("repeat_break", 10'h11C);

    send(8'hE0);
    settle();
    d_rst_n = 0; tick(); d_rst_n = 1;
    chk("midseq_rst_count", 32'(bus.ev_count), 0);
    send(8'h75);
    settle();
    pop_expect("after_rst", 10'h075);
    d_ovf = 1; tick(); d_ovf = 0;
    chk("ps2_overflow", 32'(bus.ev_ovf), 1);
    d_clr = 1; tick(); d_clr = 0;

    // Randomised traffic including prefixes, drops, overflow, en toggles and resets.
    for (int c = 0; c < 4000; c++) begin
      if (src_q.size() < 3 && $urandom_range(2) == 0) send(tbl[$urandom_range(15)]);
      d_rd    = ($urandom_range(3) == 0);
      d_clr   = ($urandom_range(49) == 0);
      d_ovf   = ($urandom_range(149) == 0);
      if ($urandom_range(199) == 0) d_en = ~d_en;
      d_rst_n = ($urandom_range(599) != 0);
      tick();
    end
    d_rd = 0; d_clr = 0; d_ovf = 0; d_en = 1; d_rst_n = 1;
    settle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
